// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit between EX and a word-wide memory port
//
// Purpose: accepts one load or store from EX, issues a word-aligned memory request
// with byte enables, holds it until mem_ack, and for loads returns the extended
// lane through a one-cycle writeback pulse. Illegal or misaligned requests raise
// a one-cycle lsu_err instead.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ex_valid, ex_is_load/store    EX-stage request and its class
//   ex_funct3, ex_addr            access size/sign and effective address
//   ex_wdata, ex_rd               store data and load destination
//   stall                         hold upstream while busy or accepting
//   mem_req/we/addr/wdata/be      memory request, held until mem_ack
//   mem_ack, mem_rdata            memory completion and read word
//   wb_valid, wb_rd, wb_data      load writeback pulse
//   lsu_err                       one-cycle illegal/misaligned pulse

module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operation context kept for the response path.
    logic        op_is_load;
    logic [2:0]  op_funct3;
    logic [1:0]  op_off;
    logic [4:0]  op_rd;

    logic        funct3_legal;
    logic        addr_aligned;
    logic        mem_op;
    logic        accept;
    logic        reject;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] load_shifted;
    logic [31:0] load_result;

    // Request decode ----------------------------------------------------------

    always_comb begin
        funct3_legal = 1'b0;
        case (ex_funct3)
            3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
            3'b100, 3'b101:         funct3_legal = ex_is_load;
            default:                funct3_legal = 1'b0;
        endcase
    end

    // funct3[1:0] encodes the access size for every legal code.
    always_comb begin
        addr_aligned = 1'b1;
        case (ex_funct3[1:0])
            2'b01:   addr_aligned = ~ex_addr[0];
            2'b10:   addr_aligned = (ex_addr[1:0] == 2'b00);
            default: addr_aligned = 1'b1;
        endcase
    end

    // Any classed request seen in IDLE either accepts or errors; ex_valid
    // without a class is a non-memory instruction and is ignored.
    assign mem_op = (state == IDLE) && ex_valid && (ex_is_load || ex_is_store);
    assign accept = mem_op && (ex_is_load ^ ex_is_store) && funct3_legal && addr_aligned;
    assign reject = mem_op && !accept;

    // Stall must already be high in the accept cycle so EX does not advance.
    assign stall = !rst && ((state != IDLE) || accept);

    always_comb begin
        req_be = 4'b1111;
        case (ex_funct3[1:0])
            2'b00:   req_be = 4'b0001 << ex_addr[1:0];
            2'b01:   req_be = 4'b0011 << ex_addr[1:0];
            default: req_be = 4'b1111;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone select it.
    always_comb begin
        req_wdata = 32'd0;
        if (ex_is_store) begin
            case (ex_funct3[1:0])
                2'b00:   req_wdata = {4{ex_wdata[7:0]}};
                2'b01:   req_wdata = {2{ex_wdata[15:0]}};
                default: req_wdata = ex_wdata;
            endcase
        end
    end

    // Response lane select and extension -------------------------------------

    assign load_shifted = mem_rdata >> {op_off, 3'b000};

    always_comb begin
        load_result = mem_rdata;
        case (op_funct3)
            3'b000:  load_result = {{24{load_shifted[7]}},  load_shifted[7:0]};
            3'b001:  load_result = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_result = {24'd0, load_shifted[7:0]};
            3'b101:  load_result = {16'd0, load_shifted[15:0]};
            default: load_result = mem_rdata;
        endcase
    end

    // FSM ---------------------------------------------------------------------

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_next = op_is_load ? WB : IDLE;
                end
            end
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered request/response outputs ------------------------------------

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            lsu_err    <= 1'b0;
            op_is_load <= 1'b0;
            op_funct3  <= 3'd0;
            op_off     <= 2'd0;
            op_rd      <= 5'd0;
        end else begin
            lsu_err <= reject;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_req    <= 1'b1;
                        mem_we     <= ex_is_store;
                        mem_addr   <= {ex_addr[31:2], 2'b00};
                        mem_be     <= req_be;
                        mem_wdata  <= req_wdata;
                        op_is_load <= ex_is_load;
                        op_funct3  <= ex_funct3;
                        op_off     <= ex_addr[1:0];
                        op_rd      <= ex_rd;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (op_is_load) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= op_rd;
                            wb_data  <= load_result;
                        end
                    end
                end
                WB: begin
                    wb_valid <= 1'b0;
                end
                default: begin
                    wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural reference model

module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_err;

    int n_tests;
    int n_fail;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_is_store(ex_is_store),
        .ex_funct3  (ex_funct3),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_rd      (ex_rd),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .lsu_err    (lsu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations captured by run_op
    logic        o_acc_stall;
    int          o_req_cycles;
    int          o_first_req_c;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_be;
    logic        o_we;
    logic        o_stable;
    int          o_wb_cnt;
    int          o_wb_c;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    int          o_err_cnt;
    int          o_err_c;
    int          o_stall_cnt;

    // Reference model ---------------------------------------------------------

    function automatic logic ref_accept(input logic ld, input logic st,
                                        input logic [2:0] f3, input logic [31:0] a);
        int  sz;
        logic fok;
        logic aok;
        if (ld == st) return 1'b0;
        if (ld) fok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else    fok = (f3 <= 2);
        sz  = int'(f3) % 4;
        aok = (sz == 0) || (sz == 1 && a % 2 == 0) || (sz == 2 && a % 4 == 0);
        return fok && aok;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] t;
        int sz;
        sz = int'(f3) % 4;
        if (sz == 0)      t = 32'd1 << (a % 4);
        else if (sz == 1) t = 32'd3 << (a % 4);
        else              t = 32'd15;
        return t[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic st, input logic [2:0] f3,
                                              input logic [31:0] wd);
        int sz;
        if (!st) return 32'd0;
        sz = int'(f3) % 4;
        if (sz == 0) return (wd % 256) * 32'h0101_0101;
        if (sz == 1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd_word);
        logic [31:0] v;
        v = rd_word >> ((a % 4) * 8);
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: v = rd_word;
        endcase
        return v;
    endfunction

    // Driver: presents one request, plays a memory acking after d extra cycles,
    // and records what the DUT did over a fixed window. No checking here.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input int d, input logic [31:0] rword, input int window);
        o_acc_stall = 1'b0; o_req_cycles = 0; o_first_req_c = 0;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0; o_stable = 1'b1;
        o_wb_cnt = 0; o_wb_c = 0; o_wb_rd = '0; o_wb_data = '0;
        o_err_cnt = 0; o_err_c = 0; o_stall_cnt = 0;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_addr = a; ex_wdata = wd; ex_rd = rd;
        mem_ack = ($urandom_range(0, 1) == 1); mem_rdata = $urandom;
        #1 o_acc_stall = stall;
        for (int c = 1; c <= window; c++) begin
            @(posedge clk); #1;
            ex_valid = 1'b0;
            if (mem_req) begin
                if (o_req_cycles == 0) begin
                    o_first_req_c = c; o_addr = mem_addr; o_wdata = mem_wdata;
                    o_be = mem_be; o_we = mem_we;
                end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                             mem_be !== o_be || mem_we !== o_we) begin
                    o_stable = 1'b0;
                end
                o_req_cycles++;
                if (o_req_cycles - 1 == d) begin mem_ack = 1'b1; mem_rdata = rword; end
                else begin mem_ack = 1'b0; mem_rdata = $urandom; end
            end else begin
                mem_ack = ($urandom_range(0, 1) == 1); mem_rdata = $urandom;
            end
            if (wb_valid) begin o_wb_cnt++; o_wb_c = c; o_wb_rd = wb_rd; o_wb_data = wb_data; end
            if (lsu_err)  begin o_err_cnt++; o_err_c = c; end
            if (stall)    o_stall_cnt++;
        end
        mem_ack = 1'b0;
    endtask

    // Tests -------------------------------------------------------------------

    task automatic test_reset;
        rst = 1'b1; ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
        ex_funct3 = 3'b010; ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd5;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({mem_req, mem_we, wb_valid, lsu_err, stall} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, wb_valid, lsu_err, stall});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, mem_be, wb_rd, wb_data} !== 105'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, mem_be, wb_rd, wb_data});
        end
        ex_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({mem_req, stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 00", {mem_req, stall});
        end
    endtask

    task automatic test_lb;
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 3, 32'h80FF_FFFF, 10);
        n_tests++;
        if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h expected 00000100", o_addr); end
        n_tests++;
        if (o_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b expected 1000", o_be); end
        n_tests++;
        if (o_wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", o_wb_data); end
        n_tests++;
        if (o_wb_cnt != 1 || o_wb_c != 5) begin
            n_fail++; $display("FAIL lb_wb: got cnt %0d cyc %0d expected cnt 1 cyc 5", o_wb_cnt, o_wb_c);
        end
        n_tests++;
        if (!o_acc_stall || o_stall_cnt != 5 || !o_stable) begin
            n_fail++;
            $display("FAIL lb_stall: got acc %b cnt %0d stable %b expected 1 5 1", o_acc_stall, o_stall_cnt, o_stable);
        end
    endtask

    task automatic test_lhu;
        run_op(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 5'd3, 0, 32'hBEEF_1234, 6);
        n_tests++;
        if (o_wb_data !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_data: got %h expected 0000beef", o_wb_data); end
        n_tests++;
        if (o_first_req_c != 1 || o_wb_c != 2 || o_wb_rd !== 5'd3) begin
            n_fail++;
            $display("FAIL lhu_latency: got req %0d wb %0d rd %0d expected 1 2 3", o_first_req_c, o_wb_c, o_wb_rd);
        end
    endtask

    task automatic test_sb;
        run_op(1'b0, 1'b1, 3'b000, 32'h7, 32'h1234_56AB, 5'd9, 1, 32'h0, 7);
        n_tests++;
        if ({o_addr, o_be, o_wdata, o_we} !== {32'h4, 4'b1000, 32'hABAB_ABAB, 1'b1}) begin
            n_fail++;
            $display("FAIL sb_req: got %h %b %h %b expected 00000004 1000 abababab 1", o_addr, o_be, o_wdata, o_we);
        end
        n_tests++;
        if (o_wb_cnt != 0 || o_req_cycles != 2) begin
            n_fail++; $display("FAIL sb_done: got wb %0d req %0d expected 0 2", o_wb_cnt, o_req_cycles);
        end
    endtask

    task automatic test_illegal;
        logic [2:0]  f3s [3]  = '{3'b010, 3'b011, 3'b010};
        logic [31:0] as  [3]  = '{32'h102, 32'h100, 32'h100};
        logic        sts [3]  = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, sts[i], f3s[i], as[i], 32'h0, 5'd1, 0, 32'h0, 4);
            n_tests++;
            if (o_req_cycles != 0 || o_err_cnt != 1 || o_err_c != 1 || o_acc_stall || o_stall_cnt != 0) begin
                n_fail++;
                $display("FAIL illegal_%0d: got req %0d err %0d@%0d stall %b/%0d expected 0 1@1 0/0",
                         i, o_req_cycles, o_err_cnt, o_err_c, o_acc_stall, o_stall_cnt);
            end
        end
    endtask

    task automatic test_rd_zero;
        run_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd0, 2, 32'h1357_9BDF, 8);
        n_tests++;
        if (o_wb_cnt != 1 || o_wb_rd !== 5'd0 || o_wb_data !== 32'h1357_9BDF) begin
            n_fail++;
            $display("FAIL rd_zero: got cnt %0d rd %0d data %h expected 1 0 13579bdf", o_wb_cnt, o_wb_rd, o_wb_data);
        end
    endtask

    task automatic test_reset_busy;
        int wbs;
        int errs;
        int reqs;
        int stalls;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b1; ex_funct3 = 3'b010;
        ex_addr = 32'h40; ex_wdata = 32'hDEAD_BEEF; mem_ack = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        n_tests++;
        if ({mem_req, stall} !== 2'b11) begin n_fail++; $display("FAIL rstbusy_pre: got %b expected 11", {mem_req, stall}); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({mem_req, mem_we, stall} !== 3'b000) begin
            n_fail++; $display("FAIL rstbusy_async: got %b expected 000", {mem_req, mem_we, stall});
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
        wbs = 0; errs = 0; reqs = 0; stalls = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (wb_valid) wbs++;
            if (lsu_err)  errs++;
            if (mem_req)  reqs++;
            if (stall)    stalls++;
        end
        n_tests++;
        if (wbs != 0 || errs != 0 || reqs != 0 || stalls != 0) begin
            n_fail++;
            $display("FAIL rstbusy_after: got wb %0d err %0d req %0d stall %0d expected 0 0 0 0", wbs, errs, reqs, stalls);
        end
    endtask

    task automatic test_back_to_back;
        int cnt0;
        int cnt4;
        int wbs;
        int first_wb_c;
        int second_req_c;
        logic [31:0] wdat [2];
        cnt0 = 0; cnt4 = 0; wbs = 0; first_wb_c = 0; second_req_c = 0;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
        ex_addr = 32'h0; ex_rd = 5'd1; mem_ack = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin ex_addr = 32'h4; ex_rd = 5'd2; end
            mem_ack = mem_req;
            mem_rdata = mem_addr ^ 32'hA5A5_0000;
            if (mem_req && mem_addr == 32'h0) cnt0++;
            if (mem_req && mem_addr == 32'h4) begin
                cnt4++;
                if (second_req_c == 0) second_req_c = c;
                ex_valid = 1'b0;
            end
            if (wb_valid) begin
                if (wbs < 2) wdat[wbs] = wb_data;
                if (wbs == 0) first_wb_c = c;
                wbs++;
            end
        end
        mem_ack = 1'b0; ex_valid = 1'b0;
        n_tests++;
        if (cnt0 != 1 || cnt4 != 1) begin
            n_fail++; $display("FAIL b2b_issue: got %0d %0d expected 1 1", cnt0, cnt4);
        end
        n_tests++;
        if (wbs != 2 || second_req_c <= first_wb_c) begin
            n_fail++;
            $display("FAIL b2b_order: got wb %0d req2@%0d wb1@%0d expected 2 and req2 after wb1", wbs, second_req_c, first_wb_c);
        end
        n_tests++;
        if (wbs == 2 && (wdat[0] !== 32'hA5A5_0000 || wdat[1] !== 32'hA5A5_0004)) begin
            n_fail++; $display("FAIL b2b_data: got %h %h expected a5a50000 a5a50004", wdat[0], wdat[1]);
        end
    endtask

    task automatic test_random;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rw;
        logic [4:0]  rd;
        logic        ok;
        int          d;
        int          sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            ld  = (sel <= 2) || (sel == 6);
            st  = (sel >= 3 && sel <= 6);
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a = a - (a % 4);
            wd  = $urandom; rw = $urandom;
            rd  = 5'($urandom_range(0, 31));
            d   = $urandom_range(0, 3);
            ok  = ref_accept(ld, st, f3, a);
            run_op(ld, st, f3, a, wd, rd, d, rw, ok ? d + 6 : 4);
            if (ok) begin
                n_tests++;
                if ({o_addr, o_be, o_wdata, o_we} !== {a - (a % 4), ref_be(f3, a), ref_wdata(st, f3, wd), st}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_req: got %h %b %h %b expected %h %b %h %b", i, o_addr, o_be, o_wdata, o_we,
                             a - (a % 4), ref_be(f3, a), ref_wdata(st, f3, wd), st);
                end
                n_tests++;
                if (o_first_req_c != 1 || o_req_cycles != d + 1 || !o_stable || o_err_cnt != 0 || !o_acc_stall) begin
                    n_fail++;
                    $display("FAIL rnd%0d_hs: got req@%0d len %0d stable %b err %0d acc %b expected 1 %0d 1 0 1",
                             i, o_first_req_c, o_req_cycles, o_stable, o_err_cnt, o_acc_stall, d + 1);
                end
                n_tests++;
                if (ld && (o_wb_cnt != 1 || o_wb_c != d + 2 || o_wb_rd !== rd ||
                           o_wb_data !== ref_load(f3, a, rw) || o_stall_cnt != d + 2)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_load: got wb %0d@%0d rd %0d data %h stall %0d expected 1@%0d %0d %h %0d",
                             i, o_wb_cnt, o_wb_c, o_wb_rd, o_wb_data, o_stall_cnt, d + 2, rd, ref_load(f3, a, rw), d + 2);
                end else if (st && (o_wb_cnt != 0 || o_stall_cnt != d + 1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_store: got wb %0d stall %0d expected 0 %0d", i, o_wb_cnt, o_stall_cnt, d + 1);
                end
            end else begin
                n_tests++;
                if (o_req_cycles != 0 || o_wb_cnt != 0 || o_acc_stall || o_stall_cnt != 0 ||
                    o_err_cnt != ((ld || st) ? 1 : 0)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_rej: got req %0d wb %0d stall %b/%0d err %0d expected 0 0 0/0 %0d",
                             i, o_req_cycles, o_wb_cnt, o_acc_stall, o_stall_cnt, o_err_cnt, (ld || st) ? 1 : 0);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset;
        test_lb;
        test_lhu;
        test_sb;
        test_illegal;
        test_rd_zero;
        test_reset_busy;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ex_valid, input, 1 bit: EX stage presents an instruction this cycle.
REQ-004 SHALL have ports ex_is_load and ex_is_store, input, 1 bit each: memory-operation class.
REQ-005 SHALL have port ex_funct3, input, 3 bits: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 SHALL have port ex_addr, input, 32 bits: effective address (ALU result).
REQ-007 SHALL have port ex_wdata, input, 32 bits: store data (rs2).
REQ-008 SHALL have port ex_rd, input, 5 bits: load destination register.
REQ-009 SHALL have port stall, output, 1 bit: hold upstream pipeline.
REQ-010 SHALL have port mem_req, output, 1 bit: memory request valid.
REQ-011 SHALL have port mem_we, output, 1 bit: 1 = write.
REQ-012 SHALL have ports mem_addr and mem_wdata, output, 32 bits each.
REQ-013 SHALL have port mem_be, output, 4 bits: byte enables, bit i = byte lane i.
REQ-014 SHALL have port mem_ack, input, 1 bit: memory completes the request this cycle.
REQ-015 SHALL have port mem_rdata, input, 32 bits: read word, valid while mem_ack=1.
REQ-016 SHALL have ports wb_valid (1 bit), wb_rd (5 bits) and wb_data (32 bits), all outputs: load writeback.
REQ-017 SHALL have port lsu_err, output, 1 bit: one-cycle misaligned/illegal-op pulse.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY and WB.
REQ-019 Accept SHALL occur when state=IDLE, ex_valid=1, exactly one of ex_is_load/ex_is_store=1, funct3 is legal for the class, and the address is aligned.
REQ-020 Alignment SHALL be defined as: H/HU require addr[0]=0; W requires addr[1:0]=00; B/BU are always aligned.
REQ-021 Legal funct3 values SHALL be: loads 000, 001, 010, 100, 101; stores 000, 001, 010.
REQ-022 On accept: next state BUSY; mem_req=1 from the next cycle; mem_addr={ex_addr[31:2],2'b00}; mem_we=ex_is_store; operands and ex_rd registered.
REQ-023 SB SHALL drive mem_be=0001<<addr[1:0] and mem_wdata={4{wdata[7:0]}}.
REQ-024 SH SHALL drive mem_be=0011<<addr[1:0] and mem_wdata={2{wdata[15:0]}}.
REQ-025 SW SHALL drive mem_be=1111 and mem_wdata=wdata.
REQ-026 Loads SHALL drive mem_be per REQ-023 to REQ-025 and mem_wdata=0.
REQ-027 mem_req, mem_we, mem_addr, mem_be and mem_wdata SHALL be held stable in BUSY until the cycle mem_ack=1 inclusive.
REQ-028 mem_ack in BUSY, store: next state IDLE; mem_req=0 next cycle; no wb_valid.
REQ-029 mem_ack in BUSY, load: capture the selected lane of mem_rdata, sign-extend (B/H) or zero-extend (BU/HU), go to WB.
REQ-030 WB SHALL assert wb_valid=1 for exactly one cycle with wb_rd and wb_data, then go to IDLE.
REQ-031 Minimum latency: accept at T, mem_req at T+1, ack at T+1 at earliest, wb_valid at T+2.
REQ-032 A load with rd=0 SHALL still complete the access, with wb_valid=1 and wb_rd=0.
REQ-033 stall SHALL be combinational: 1 when state is BUSY or WB, or when an accept occurs this cycle; otherwise 0.
REQ-034 An illegal or misaligned request in IDLE SHALL not be accepted, SHALL issue no mem_req, and SHALL pulse lsu_err the next cycle; stall=0.
REQ-035 A request with both ex_is_load and ex_is_store set SHALL be treated as illegal per REQ-034.
REQ-036 mem_ack received in IDLE or WB SHALL be ignored.
REQ-037 ex_* inputs while in BUSY or WB SHALL be ignored.
REQ-038 A non-memory instruction (ex_valid=1, no class) SHALL produce no effect.

Reset
REQ-039 rst=1 SHALL immediately force state to IDLE and drive mem_req, mem_we, wb_valid, lsu_err and stall to 0, and mem_addr, mem_wdata, mem_be, wb_rd and wb_data to 0.
REQ-040 Reset during BUSY SHALL abandon the request; an ack arriving after reset is ignored per REQ-036.

Verification
REQ-041 LB at addr 0x103, mem_rdata=0x80FF_FFFF, ack after 3 cycles -> mem_addr=0x100, mem_be=1000, wb_data=0xFFFF_FF80, stall high until wb_valid.
REQ-042 LHU at addr 0x202, mem_rdata=0xBEEF_1234, ack same cycle as mem_req -> wb_data=0x0000_BEEF, wb_valid at T+2.
REQ-043 SB of wdata=0x1234_56AB at addr 0x7 -> mem_addr=0x4, mem_be=1000, mem_wdata=0xABAB_ABAB, mem_we=1, no wb_valid.
REQ-044 LW at addr 0x102 -> no mem_req, lsu_err pulse 1 cycle, stall=0; ex_funct3=011 load -> same response.
REQ-045 SW accepted, rst asserted in BUSY, then mem_ack pulsed -> mem_req=0 asynchronously, state IDLE, no wb_valid, no lsu_err.
REQ-046 Back-to-back LW, LW at 0x0 and 0x4 -> second request accepted only after the first wb_valid, and each address issued exactly once.
